// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the MEM stage: word-aligned accesses to a 32-bit data
// memory, with byte-lane extraction for sub-word loads and read-modify-write for sub-word stores.
module dmem_access_ctrl #(
  parameter int REG_WIDTH       = 32,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DMEM_DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]       req_wdata,
  output logic                       resp_valid,
  output logic [REG_WIDTH-1:0]       resp_rdata,
  output logic                       resp_err,
  output logic                       dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]       dmem_wr_data,
  input  logic [REG_WIDTH-1:0]       dmem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, MERGE_WR, WR, RESP} state_t;

  localparam logic [31:0] MAX_ALIGNED = 32'(DMEM_DEPTH - 4);

  state_t                 state;
  logic                   we_q;
  logic [2:0]             funct3_q;
  logic [1:0]             lane_q;
  logic [REG_WIDTH-1:0]   wdata_q;

  logic [DMEM_ADDR_WIDTH-1:0] aligned_addr;
  logic                       req_err;
  logic [REG_WIDTH-1:0]       load_data;
  logic [REG_WIDTH-1:0]       merged_word;
  logic [7:0]                 lane_byte;
  logic [15:0]                lane_half;

  assign aligned_addr = {req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (32'(aligned_addr) > MAX_ALIGNED) req_err = 1'b1;
  end

  assign lane_byte = dmem_data_out[{lane_q, 3'b000} +: 8];
  assign lane_half = dmem_data_out[{lane_q[1], 4'b0000} +: 16];

  // funct3[2] selects zero extension; funct3[1:0] selects the access size.
  always_comb begin
    load_data = dmem_data_out;
    case (funct3_q)
      3'b000:  load_data = {{(REG_WIDTH-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{(REG_WIDTH-16){lane_half[15]}}, lane_half};
      3'b100:  load_data = {{(REG_WIDTH-8){1'b0}}, lane_byte};
      3'b101:  load_data = {{(REG_WIDTH-16){1'b0}}, lane_half};
      default: load_data = dmem_data_out;
    endcase
  end

  // Only SB and SH take the read-modify-write path, so funct3[0] picks half vs byte.
  always_comb begin
    merged_word = dmem_data_out;
    if (funct3_q[0]) merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merged_word[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      dmem_wr_en   <= 1'b0;
      dmem_addr    <= '0;
      dmem_wr_data <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_funct3 == 3'b010) begin
              state        <= WR;
              dmem_addr    <= aligned_addr;
              dmem_wr_en   <= 1'b1;
              dmem_wr_data <= req_wdata;
            end else begin
              state     <= RD;
              dmem_addr <= aligned_addr;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state        <= MERGE_WR;
            dmem_wr_en   <= 1'b1;
            dmem_wr_data <= merged_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        MERGE_WR, WR: begin
          state      <= RESP;
          dmem_wr_en <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          dmem_wr_en <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: byte-level reference memory predicts every
// response, a negedge monitor compares data, error, latency and write-pulse count.
module tb_dmem_access_ctrl;

  localparam int RW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 768;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [RW-1:0] req_wdata;
  logic          resp_valid;
  logic [RW-1:0] resp_rdata;
  logic          resp_err;
  logic          dmem_wr_en;
  logic [AW-1:0] dmem_addr;
  logic [RW-1:0] dmem_wr_data;
  logic [RW-1:0] dmem_data_out = '0;

  dmem_access_ctrl #(.REG_WIDTH(RW), .DMEM_ADDR_WIDTH(AW), .DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_data_out(dmem_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [31:0] mem_w   [0:255];   // the memory the DUT talks to
  logic [7:0]  ref_mem [0:1023];  // the reference model's view, byte addressed

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) dmem_data_out = mem_w[dmem_addr[9:2]];
  always @(posedge clk) if (dmem_wr_en) mem_w[dmem_addr[9:2]] <= dmem_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) wr_cnt = 0;
    else begin
      if (dmem_wr_en) begin
        wr_cnt++;
        check("wr_addr_aligned", 32'(dmem_addr[1:0]), 32'd0);
        check("ready_during_write", 32'(req_ready), 32'd0);
      end
      if (resp_valid) begin
        check("ready_during_resp", 32'(req_ready), 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", 32'(resp_err), 32'(mon_e.err));
          check("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          check("wr_pulses", 32'(wr_cnt), 32'(mon_e.wr));
          wr_cnt = 0;
        end
      end
    end
  end

  // Reference model: decides the outcome from the access rules on a byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, output exp_t e);
    int base, size, ai;
    logic [31:0] v;
    ai   = int'(a);
    base = ai - (ai % 4);
    e.rdata = 32'd0; e.err = 1'b0; e.wr = 0; e.lat = 1; e.acc = 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)   e.err = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5))         e.err = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && ai % 2 != 0) e.err = 1'b1;
    if (f3 == 3'd2 && ai % 4 != 0)                e.err = 1'b1;
    if (base > DEPTH - 4)                         e.err = 1'b1;
    if (e.err) return;
    size = 1 << f3[1:0];
    if (we) begin
      e.wr  = 1;
      e.lat = (size == 4) ? 2 : 3;
      for (int i = 0; i < size; i++) ref_mem[ai + i] = wd[8*i +: 8];
    end else begin
      e.lat = 2;
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[ai + i]) << (8 * i));
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
    end
  endtask

  // Presents a request, waits for acceptance, pushes the expectation at the accept edge.
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                           input logic [31:0] wd, input bit keep, input exp_t e, input bit push);
    bit ok;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) begin
        e.acc = cyc;
        @(posedge clk);
        if (push) q.push_back(e);
        ok = 1'b1;
      end else @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1 at cycle %0d", cyc);
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, input bit keep, input bit use_exp,
                       input logic [31:0] exp_rdata);
    exp_t e;
    model(we, f3, a, wd, e);
    if (use_exp) e.rdata = exp_rdata;
    drive_req(we, f3, a, wd, keep, e, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t dummy;
    bit seen;
    logic [2:0] f3;
    logic [AW-1:0] a;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 256; i++) begin
      mem_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem_w[i][8*b +: 8];
    end
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_wr_en", 32'(dmem_wr_en), 32'd0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    check("rst_wr_data", dmem_wr_data, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 3'd2, 10'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 10'h010, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);

    issue(1'b1, 3'd2, 10'h020, 32'h80FF7F01, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 3'd0, 10'h023, 32'd0, 1'b0, 1'b1, 32'hFFFFFF80);
    issue(1'b0, 3'd4, 10'h023, 32'd0, 1'b0, 1'b1, 32'h00000080);
    issue(1'b0, 3'd1, 10'h022, 32'd0, 1'b0, 1'b1, 32'hFFFF80FF);
    issue(1'b0, 3'd5, 10'h020, 32'd0, 1'b0, 1'b1, 32'h00007F01);

    issue(1'b1, 3'd2, 10'h030, 32'h11223344, 1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'd0, 10'h031, 32'h000000AA, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 10'h030, 32'd0, 1'b0, 1'b1, 32'h1122AA44);
    issue(1'b1, 3'd1, 10'h032, 32'h0000BEEF, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 10'h030, 32'd0, 1'b0, 1'b1, 32'hBEEFAA44);

    issue(1'b0, 3'd2, 10'h042, 32'd0, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 3'd1, 10'h045, 32'd0, 1'b0, 1'b1, 32'd0);
    issue(1'b1, 3'd2, 10'(DEPTH - 2), 32'h12345678, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 3'd3, 10'h000, 32'd0, 1'b0, 1'b1, 32'd0);
    issue(1'b1, 3'd4, 10'h000, 32'h55, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 3'd2, 10'(DEPTH), 32'd0, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 3'd0, 10'h3FF, 32'd0, 1'b0, 1'b1, 32'd0);

    issue(1'b1, 3'd2, 10'h100, 32'h12345678, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 10'h100, 32'd0, 1'b1, 1'b1, 32'h12345678);
    issue(1'b1, 3'd0, 10'h102, 32'h0000009C, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 3'd4, 10'h102, 32'd0, 1'b0, 1'b1, 32'h0000009C);

    // Abort an SB during its merge write: nothing may be committed or answered.
    dummy = '{rdata: 32'd0, err: 1'b0, lat: 0, wr: 0, acc: 0};
    drive_req(1'b1, 3'd0, 10'h035, 32'h000000C3, 1'b0, dummy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (dmem_wr_en) seen = 1'b1;
      else @(negedge clk);
    end
    check("merge_wr_reached", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(dmem_wr_en), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("post_abort_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 3'd2, 10'h034, 32'd0, 1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       f3 = 3'd3 + 3'($urandom_range(0, 1) * 3);
        1, 2:    f3 = 3'd0;
        3, 4:    f3 = 3'd1;
        5, 6:    f3 = 3'd2;
        7:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      a = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~(10'(1 << f3[1:0]) - 10'd1);
      issue(1'($urandom_range(0, 1)), f3, a, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
